tinker_io_port: RTL
===================

Name: tinker_io_port

Overview:
Buffers the CPU's 64-bit I/O between the core and an external host, downstream of the CPU's out_signal/out_data and upstream of its in_signal/in_data.
- Output path: one FIFO that captures each CPU output pulse and drains it to the host over valid/ready.
- Input path: one FIFO that the host fills over valid/ready; its head is presented to the CPU and popped on each CPU in_signal pulse.
- Sticky overflow/underflow flags feed the system error/halt logic.

Parameters:
DEPTH, 8, entries per FIFO; power of two, >= 2
WIDTH, 64, data word width in bits

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
cpu_out_signal  input  1  one-cycle pulse from CPU; push cpu_out_data into output FIFO
cpu_out_data  input  WIDTH  word written by CPU
cpu_in_signal  input  1  one-cycle pulse from CPU; CPU has consumed cpu_in_data, pop input FIFO
cpu_in_data  output  WIDTH  head of input FIFO; 0 when input FIFO empty
host_out_valid  output  1  output FIFO non-empty
host_out_ready  input  1  host accepts host_out_data this cycle
host_out_data  output  WIDTH  head of output FIFO; 0 when empty
host_in_valid  input  1  host offers host_in_data
host_in_ready  output  1  input FIFO not full
host_in_data  input  WIDTH  word from host
in_count  output  $clog2(DEPTH)+1  entries in input FIFO
out_count  output  $clog2(DEPTH)+1  entries in output FIFO
overflow  output  1  sticky: CPU pushed while output FIFO full
underflow  output  1  sticky: CPU popped while input FIFO empty
err_clear  input  1  synchronous clear of overflow and underflow

Behaviour:
- Reset (reset=0, async):
  - Both FIFOs empty; pointers and counts 0; overflow=0, underflow=0.
  - host_out_valid=0, host_in_ready=1, cpu_in_data=0, host_out_data=0.
  - Storage contents need not be cleared.
  - Reset asserted mid-transfer discards all buffered data; no partial push or pop completes.
- Each FIFO: DEPTH-entry circular buffer with read/write pointers of $clog2(DEPTH) bits (wrap modulo DEPTH) and a separate count of $clog2(DEPTH)+1 bits.
  - full when count==DEPTH; empty when count==0.
- Read data is combinational from storage[rd_ptr], gated to 0 when empty.
  - The CPU samples cpu_in_data in the same cycle it asserts cpu_in_signal, so the head must be valid before the edge.
  - No read latency.
- Output FIFO:
  - Push: cpu_out_signal=1 and not full. Data written at wr_ptr; wr_ptr++.
  - cpu_out_signal=1 while full: word dropped, no state change, overflow<=1.
  - Pop: host_out_valid && host_out_ready; rd_ptr++.
  - Push and pop in the same cycle: both occur and count is unchanged. When full, the pop frees space that same cycle, so the push is accepted and overflow is not set.
- Input FIFO:
  - Push: host_in_valid && host_in_ready. host_in_ready = !full, with no combinational dependence on host_in_valid.
  - Pop: cpu_in_signal=1 and not empty.
  - cpu_in_signal=1 while empty: no pointer change, underflow<=1. The CPU saw cpu_in_data=0.
  - Simultaneous push and pop when empty: the pop is an underflow; the push still lands and count becomes 1.
  - Simultaneous push and pop when full cannot occur (ready=0).
- Sticky flags:
  - Set has priority over err_clear in the same cycle.
  - The flags are cleared only by err_clear=1 or by reset.
- Latency:
  - A word pushed by the CPU is visible on host_out_data/host_out_valid in the next cycle.
  - A host word is visible on cpu_in_data in the next cycle.
  - Throughput is one word per cycle per direction.
- Counts update on the clock edge and reflect post-operation occupancy.

Test Plan:
- Reset then idle → host_out_valid=0, host_in_ready=1, cpu_in_data=0, counts 0, flags 0.
- CPU pulses cpu_out_signal with 64'h11, 64'h22, 64'h33 while host_out_ready=0, then ready=1 for 3 cycles → out_count rises 1,2,3; host sees 11,22,33 in order; host_out_valid drops after the third pop.
- Host pushes 64'hA0..64'hA7 (8 words, DEPTH=8) → host_in_ready=0 after the 8th. CPU pops one → cpu_in_data=A0 before the pop edge, then A1; host_in_ready=1 again. Pushing A8 then exercises pointer wrap, and A8 is read out after A7.
- Fill output FIFO (8 words), push 64'hFF with host_out_ready=0 → FF dropped, overflow=1, out_count=8. Repeat with host_out_ready=1 in the same cycle → FF accepted, overflow not newly set.
- cpu_in_signal on empty input FIFO → cpu_in_data=0, underflow=1. err_clear=1 for one cycle → underflow=0. err_clear coincident with a new underflow → flag stays 1.
- Drive reset=0 asynchronously mid-stream with both FIFOs half full → all outputs reach reset values before the next clk edge; after release, the FIFOs are empty and a fresh push/pop works.

Source files
------------

// File: rtl/tinker_io_port.sv
// Purpose: buffers 64-bit CPU I/O to and from an external host through two circular FIFOs, with sticky overflow and underflow flags.
// Latency: a pushed word reaches the opposite side's head one cycle later, and read data is combinational from the FIFO head.
// Backpressure: host_in_ready is !full. A CPU push into a full output FIFO is dropped and sets overflow, unless the host pops in the same cycle.

module tinker_io_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot the same cycle, so a push into a full FIFO with a concurrent pop is accepted.
    assign do_push = push && (!full || do_pop);
    assign rd_dat  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end
endmodule

module tinker_io_port #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_out_signal,
    input  logic [WIDTH-1:0]         cpu_out_data,
    input  logic                     cpu_in_signal,
    output logic [WIDTH-1:0]         cpu_in_data,
    output logic                     host_out_valid,
    input  logic                     host_out_ready,
    output logic [WIDTH-1:0]         host_out_data,
    input  logic                     host_in_valid,
    output logic                     host_in_ready,
    input  logic [WIDTH-1:0]         host_in_data,
    output logic [$clog2(DEPTH):0]   in_count,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clear
);
    logic out_full;
    logic out_empty;
    logic out_pop;
    logic in_full;
    logic in_empty;
    logic ovf_set;
    logic unf_set;

    assign host_out_valid = !out_empty;
    assign host_in_ready  = !in_full;
    assign out_pop        = host_out_valid && host_out_ready;
    assign ovf_set        = cpu_out_signal && out_full && !out_pop;
    assign unf_set        = cpu_in_signal && in_empty;

    tinker_io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_out_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (cpu_out_signal),
        .wr_dat (cpu_out_data),
        .pop    (out_pop),
        .rd_dat (host_out_data),
        .count  (out_count),
        .full   (out_full),
        .empty  (out_empty)
    );

    tinker_io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_in_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (host_in_valid && host_in_ready),
        .wr_dat (host_in_data),
        .pop    (cpu_in_signal),
        .rd_dat (cpu_in_data),
        .count  (in_count),
        .full   (in_full),
        .empty  (in_empty)
    );

    // A new error event wins over a coincident clear so it is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set)        overflow  <= 1'b1;
            else if (err_clear) overflow  <= 1'b0;
            if (unf_set)        underflow <= 1'b1;
            else if (err_clear) underflow <= 1'b0;
        end
    end
endmodule
